// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: req/ack data-memory access, MEM/WB register and upstream Stall.
// Optional MEM_TIMEOUT_EN abandons an access after TIMEOUT unacknowledged WAIT cycles.
module mem_stage_ctrl
`ifdef MEM_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT = 255
)
`endif
(
    input  logic        Clk,
    input  logic        Clr,
    input  logic        Mwreg,
    input  logic        Mm2reg,
    input  logic        Mwmem,
    input  logic [31:0] Malu,
    input  logic [31:0] Mb,
    input  logic [4:0]  Mrn,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        Stall,
    output logic        Err,
    output logic        Wwreg,
    output logic        Wm2reg,
    output logic [31:0] Wmo,
    output logic [31:0] Walu,
    output logic [4:0]  Wrn
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic w_access;
    logic w_misalign;
    logic w_timeout;
    logic w_req_nxt;
    logic w_err_nxt;
    logic w_wb_valid;
    logic w_wb_mem;

    assign w_access   = Mm2reg | Mwmem;
    assign w_misalign = w_access & (Malu[1:0] != 2'b00);

    // EX/MEM is frozen during an access, so the bus fields come straight from it
    assign mem_we    = Mwmem;
    assign mem_addr  = {Malu[31:2], 2'b00};
    assign mem_wdata = Mb;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] r_wait_cnt;

    // Held at zero in IDLE so it starts from zero on every WAIT entry
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_state == S_WAIT) & ~mem_ack & (r_wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_access && !w_misalign) w_state_nxt = S_WAIT;
            S_WAIT: if (mem_ack || w_timeout) w_state_nxt = S_IDLE;
        endcase
    end

    // Stall depends only on state, access, misalign and ack (never on MEM/WB)
    always_comb begin
        Stall      = 1'b0;
        w_req_nxt  = 1'b0;
        w_err_nxt  = 1'b0;
        w_wb_valid = 1'b0;
        w_wb_mem   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_access) begin
                    w_wb_valid = 1'b1;
                end else if (w_misalign) begin
                    w_err_nxt = 1'b1;
                end else begin
                    Stall     = 1'b1;
                    w_req_nxt = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    w_wb_valid = 1'b1;
                    w_wb_mem   = 1'b1;
                end else if (w_timeout) begin
                    w_err_nxt = 1'b1;
                end else begin
                    Stall     = 1'b1;
                    w_req_nxt = 1'b1;
                end
            end
        endcase
    end

    // Request/Err flags and the MEM/WB register; anything not committed is a zero bubble
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            mem_req <= 1'b0;
            Err     <= 1'b0;
            Wwreg   <= 1'b0;
            Wm2reg  <= 1'b0;
            Wmo     <= '0;
            Walu    <= '0;
            Wrn     <= '0;
        end else begin
            mem_req <= w_req_nxt;
            Err     <= w_err_nxt;
            if (w_wb_valid) begin
                Wwreg  <= Mwreg;
                Wm2reg <= w_wb_mem & Mm2reg;
                Wmo    <= (w_wb_mem & Mm2reg) ? mem_rdata : 32'h0;
                Walu   <= Malu;
                Wrn    <= Mrn;
            end else begin
                Wwreg  <= 1'b0;
                Wm2reg <= 1'b0;
                Wmo    <= '0;
                Walu   <= '0;
                Wrn    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus a randomized instruction stream
// checked against per-instruction rules (cycle count, stall pattern, bus fields, MEM/WB result).
module tb_mem_stage_ctrl;
    logic        Clk;
    logic        Clr;
    logic        Mwreg;
    logic        Mm2reg;
    logic        Mwmem;
    logic [31:0] Malu;
    logic [31:0] Mb;
    logic [4:0]  Mrn;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        Stall;
    logic        Err;
    logic        Wwreg;
    logic        Wm2reg;
    logic [31:0] Wmo;
    logic [31:0] Walu;
    logic [4:0]  Wrn;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 4;
    mem_stage_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
        .Clk(Clk), .Clr(Clr), .Mwreg(Mwreg), .Mm2reg(Mm2reg), .Mwmem(Mwmem),
        .Malu(Malu), .Mb(Mb), .Mrn(Mrn), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .Stall(Stall), .Err(Err), .Wwreg(Wwreg), .Wm2reg(Wm2reg), .Wmo(Wmo), .Walu(Walu), .Wrn(Wrn)
    );
`else
    mem_stage_ctrl dut (
        .Clk(Clk), .Clr(Clr), .Mwreg(Mwreg), .Mm2reg(Mm2reg), .Mwmem(Mwmem),
        .Malu(Malu), .Mb(Mb), .Mrn(Mrn), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .Stall(Stall), .Err(Err), .Wwreg(Wwreg), .Wm2reg(Wm2reg), .Wmo(Wmo), .Walu(Walu), .Wrn(Wrn)
    );
`endif

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic drive(input logic wreg, input logic m2reg, input logic wmem,
                         input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn);
        Mwreg  = wreg;
        Mm2reg = m2reg;
        Mwmem  = wmem;
        Malu   = alu;
        Mb     = b;
        Mrn    = rn;
    endtask

    task automatic test_reset();
        Clr = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h104, 32'h5, 5'd3);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        repeat (3) @(posedge Clk);
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (Err !== 1'b0) $display("FAIL reset_err: got %b want 0", Err); else n_pass++;
        n_checks++; if (Wwreg !== 1'b0) $display("FAIL reset_wwreg: got %b want 0", Wwreg); else n_pass++;
        n_checks++; if (Wm2reg !== 1'b0) $display("FAIL reset_wm2reg: got %b want 0", Wm2reg); else n_pass++;
        n_checks++; if (Wmo !== 32'h0) $display("FAIL reset_wmo: got %h want 0", Wmo); else n_pass++;
        n_checks++; if (Walu !== 32'h0) $display("FAIL reset_walu: got %h want 0", Walu); else n_pass++;
        n_checks++; if (Wrn !== 5'd0) $display("FAIL reset_wrn: got %0d want 0", Wrn); else n_pass++;
        @(negedge Clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        mem_ack = 1'b0;
        Clr     = 1'b0;
    endtask

    task automatic test_alu();
        @(negedge Clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h5555_AAAA, 5'd5);
        mem_ack   = 1'b0;
        mem_rdata = 32'h7777_7777;
        #1;
        n_checks++; if (Stall !== 1'b0) $display("FAIL alu_stall: got %b want 0", Stall); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL alu_req: got %b want 0", mem_req); else n_pass++;
        @(posedge Clk);
        #1;
        n_checks++; if (Wwreg !== 1'b1) $display("FAIL alu_wwreg: got %b want 1", Wwreg); else n_pass++;
        n_checks++; if (Wm2reg !== 1'b0) $display("FAIL alu_wm2reg: got %b want 0", Wm2reg); else n_pass++;
        n_checks++; if (Walu !== 32'h1234) $display("FAIL alu_walu: got %h want 1234", Walu); else n_pass++;
        n_checks++; if (Wrn !== 5'd5) $display("FAIL alu_wrn: got %0d want 5", Wrn); else n_pass++;
        n_checks++; if (Wmo !== 32'h0) $display("FAIL alu_wmo: got %h want 0", Wmo); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL alu_req_after: got %b want 0", mem_req); else n_pass++;
    endtask

    // Load acked in the 4th WAIT cycle: Stall high for 4 cycles in total
    task automatic test_load();
        @(negedge Clk);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd12);
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) @(negedge Clk);
            mem_ack   = (k == 4);
            mem_rdata = (k == 4) ? 32'hDEAD_BEEF : $urandom;
            #1;
            n_checks++; if (Stall !== 1'(k < 4)) $display("FAIL load_stall k=%0d: got %b want %b", k, Stall, k < 4); else n_pass++;
            n_checks++; if (mem_req !== 1'(k > 0)) $display("FAIL load_req k=%0d: got %b want %b", k, mem_req, k > 0); else n_pass++;
            if (k > 0) begin
                n_checks++; if (mem_we !== 1'b0) $display("FAIL load_we k=%0d: got %b want 0", k, mem_we); else n_pass++;
                n_checks++; if (mem_addr !== 32'h100) $display("FAIL load_addr k=%0d: got %h want 100", k, mem_addr); else n_pass++;
            end
            @(posedge Clk);
            #1;
            if (k < 4) begin
                n_checks++; if (Wwreg !== 1'b0) $display("FAIL load_bubble_wwreg k=%0d: got %b want 0", k, Wwreg); else n_pass++;
                n_checks++; if (Wm2reg !== 1'b0) $display("FAIL load_bubble_wm2reg k=%0d: got %b want 0", k, Wm2reg); else n_pass++;
            end else begin
                n_checks++; if (Wwreg !== 1'b1) $display("FAIL load_wwreg: got %b want 1", Wwreg); else n_pass++;
                n_checks++; if (Wm2reg !== 1'b1) $display("FAIL load_wm2reg: got %b want 1", Wm2reg); else n_pass++;
                n_checks++; if (Wmo !== 32'hDEAD_BEEF) $display("FAIL load_wmo: got %h want deadbeef", Wmo); else n_pass++;
                n_checks++; if (Wrn !== 5'd12) $display("FAIL load_wrn: got %0d want 12", Wrn); else n_pass++;
                n_checks++; if (Walu !== 32'h100) $display("FAIL load_walu: got %h want 100", Walu); else n_pass++;
                n_checks++; if (mem_req !== 1'b0) $display("FAIL load_req_drop: got %b want 0", mem_req); else n_pass++;
            end
        end
        @(negedge Clk);
        mem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    // Store acked in the first WAIT cycle (minimum latency)
    task automatic test_store();
        @(negedge Clk);
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 5'd3);
        for (int k = 0; k <= 1; k++) begin
            if (k > 0) @(negedge Clk);
            mem_ack   = (k == 1);
            mem_rdata = $urandom;
            #1;
            n_checks++; if (Stall !== 1'(k == 0)) $display("FAIL store_stall k=%0d: got %b want %b", k, Stall, k == 0); else n_pass++;
            n_checks++; if (mem_req !== 1'(k == 1)) $display("FAIL store_req k=%0d: got %b want %b", k, mem_req, k == 1); else n_pass++;
            if (k == 1) begin
                n_checks++; if (mem_we !== 1'b1) $display("FAIL store_we: got %b want 1", mem_we); else n_pass++;
                n_checks++; if (mem_addr !== 32'h200) $display("FAIL store_addr: got %h want 200", mem_addr); else n_pass++;
                n_checks++; if (mem_wdata !== 32'hCAFE_F00D) $display("FAIL store_wdata: got %h want cafef00d", mem_wdata); else n_pass++;
            end
            @(posedge Clk);
            #1;
        end
        n_checks++; if (Wwreg !== 1'b0) $display("FAIL store_wwreg: got %b want 0", Wwreg); else n_pass++;
        n_checks++; if (Wm2reg !== 1'b0) $display("FAIL store_wm2reg: got %b want 0", Wm2reg); else n_pass++;
        n_checks++; if (Wmo !== 32'h0) $display("FAIL store_wmo: got %h want 0", Wmo); else n_pass++;
        n_checks++; if (Walu !== 32'h200) $display("FAIL store_walu: got %h want 200", Walu); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL store_req_drop: got %b want 0", mem_req); else n_pass++;
        @(negedge Clk);
        mem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic test_misalign();
        @(negedge Clk);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd9);
        mem_ack = 1'b0;
        #1;
        n_checks++; if (Stall !== 1'b0) $display("FAIL mis_stall: got %b want 0", Stall); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL mis_req: got %b want 0", mem_req); else n_pass++;
        @(posedge Clk);
        #1;
        n_checks++; if (Err !== 1'b1) $display("FAIL mis_err: got %b want 1", Err); else n_pass++;
        n_checks++; if (Wwreg !== 1'b0) $display("FAIL mis_wwreg: got %b want 0", Wwreg); else n_pass++;
        n_checks++; if (Wm2reg !== 1'b0) $display("FAIL mis_wm2reg: got %b want 0", Wm2reg); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL mis_req_after: got %b want 0", mem_req); else n_pass++;
        @(negedge Clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        @(posedge Clk);
        #1;
        n_checks++; if (Err !== 1'b0) $display("FAIL mis_err_once: got %b want 0", Err); else n_pass++;
    endtask

    // Clr during the 2nd WAIT cycle abandons the load; a late ack must not update MEM/WB
    task automatic test_clr_abort();
        @(negedge Clk);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd4);
        mem_ack = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        #1;
        n_checks++; if (mem_req !== 1'b1) $display("FAIL clr_req_before: got %b want 1", mem_req); else n_pass++;
        Clr = 1'b1;
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL clr_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (Wwreg !== 1'b0) $display("FAIL clr_wwreg: got %b want 0", Wwreg); else n_pass++;
        n_checks++; if (Wm2reg !== 1'b0) $display("FAIL clr_wm2reg: got %b want 0", Wm2reg); else n_pass++;
        n_checks++; if (Wmo !== 32'h0) $display("FAIL clr_wmo: got %h want 0", Wmo); else n_pass++;
        n_checks++; if (Walu !== 32'h0) $display("FAIL clr_walu: got %h want 0", Walu); else n_pass++;
        n_checks++; if (Wrn !== 5'd0) $display("FAIL clr_wrn: got %0d want 0", Wrn); else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        @(negedge Clk);
        Clr = 1'b0;
        @(negedge Clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        #1;
        n_checks++; if (Stall !== 1'b0) $display("FAIL clr_late_stall: got %b want 0", Stall); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL clr_late_req: got %b want 0", mem_req); else n_pass++;
        @(posedge Clk);
        #1;
        n_checks++; if (Wm2reg !== 1'b0) $display("FAIL clr_late_wm2reg: got %b want 0", Wm2reg); else n_pass++;
        n_checks++; if (Wmo !== 32'h0) $display("FAIL clr_late_wmo: got %h want 0", Wmo); else n_pass++;
        n_checks++; if (Wwreg !== 1'b0) $display("FAIL clr_late_wwreg: got %b want 0", Wwreg); else n_pass++;
        @(negedge Clk);
        mem_ack = 1'b0;
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge Clk);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 5'd9);
        mem_ack = 1'b0;
        for (int k = 0; k <= int'(TB_TIMEOUT); k++) begin
            if (k > 0) @(negedge Clk);
            #1;
            n_checks++; if (Stall !== 1'(k < int'(TB_TIMEOUT))) $display("FAIL to_stall k=%0d: got %b", k, Stall); else n_pass++;
            n_checks++; if (mem_req !== 1'(k > 0)) $display("FAIL to_req k=%0d: got %b want %b", k, mem_req, k > 0); else n_pass++;
            @(posedge Clk);
            #1;
            n_checks++; if (Wwreg !== 1'b0 || Wm2reg !== 1'b0) $display("FAIL to_bubble k=%0d: got %b%b want 00", k, Wwreg, Wm2reg); else n_pass++;
            n_checks++; if (Err !== 1'(k == int'(TB_TIMEOUT))) $display("FAIL to_err k=%0d: got %b", k, Err); else n_pass++;
        end
        n_checks++; if (mem_req !== 1'b0) $display("FAIL to_req_drop: got %b want 0", mem_req); else n_pass++;
        @(negedge Clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        @(posedge Clk);
        #1;
        n_checks++; if (Err !== 1'b0) $display("FAIL to_err_once: got %b want 0", Err); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL to_req_idle: got %b want 0", mem_req); else n_pass++;
    endtask
`endif

    // Random instruction stream; each instruction's timing and result follow from its kind and ack latency
    task automatic test_back_to_back();
        int          kind;
        int          lat;
        int          ncyc;
        logic        aligned;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [31:0] alu;
        logic [31:0] b;
        logic [31:0] rdata;
        logic [4:0]  rn;
        logic        in_wait;
        logic        last;
        for (int n = 0; n < 60; n++) begin
            kind  = int'($urandom_range(0, 3));
            lat   = int'($urandom_range(1, 4));
            wreg  = 1'($urandom);
            b     = $urandom;
            rn    = 5'($urandom);
            rdata = $urandom;
            alu   = $urandom;
            m2reg = (kind == 1);
            wmem  = (kind == 2);
            if (kind == 1 || kind == 2) alu[1:0] = 2'b00;
            if (kind == 3) begin
                m2reg    = 1'($urandom);
                wmem     = ~m2reg;
                alu[1:0] = 2'($urandom_range(1, 3));
            end
            aligned = (kind == 1 || kind == 2);
            ncyc    = aligned ? lat + 1 : 1;
            for (int k = 0; k < ncyc; k++) begin
                @(negedge Clk);
                drive(wreg, m2reg, wmem, alu, b, rn);
                in_wait   = aligned && (k > 0);
                mem_ack   = in_wait ? (k == lat) : 1'($urandom);
                mem_rdata = (in_wait && k == lat) ? rdata : $urandom;
                last      = (k == ncyc - 1);
                #1;
                n_checks++; if (Stall !== (aligned && k < lat)) $display("FAIL rnd_stall n=%0d k=%0d: got %b want %b", n, k, Stall, aligned && k < lat); else n_pass++;
                n_checks++; if (mem_req !== in_wait) $display("FAIL rnd_req n=%0d k=%0d: got %b want %b", n, k, mem_req, in_wait); else n_pass++;
                if (in_wait) begin
                    n_checks++; if (mem_we !== wmem || mem_addr !== alu || mem_wdata !== b)
                        $display("FAIL rnd_bus n=%0d k=%0d: got we=%b a=%h d=%h want we=%b a=%h d=%h", n, k, mem_we, mem_addr, mem_wdata, wmem, alu, b);
                    else n_pass++;
                end
                @(posedge Clk);
                #1;
                if (last && kind != 3) begin
                    n_checks++; if (Wwreg !== wreg || Wm2reg !== (kind == 1))
                        $display("FAIL rnd_wctl n=%0d: got %b%b want %b%b", n, Wwreg, Wm2reg, wreg, kind == 1);
                    else n_pass++;
                    n_checks++; if (Walu !== alu || Wrn !== rn)
                        $display("FAIL rnd_walu n=%0d: got %h/%0d want %h/%0d", n, Walu, Wrn, alu, rn);
                    else n_pass++;
                    n_checks++; if (Wmo !== ((kind == 1) ? rdata : 32'h0))
                        $display("FAIL rnd_wmo n=%0d: got %h want %h", n, Wmo, (kind == 1) ? rdata : 32'h0);
                    else n_pass++;
                end else begin
                    n_checks++; if (Wwreg !== 1'b0 || Wm2reg !== 1'b0)
                        $display("FAIL rnd_bubble n=%0d k=%0d: got %b%b want 00", n, k, Wwreg, Wm2reg);
                    else n_pass++;
                end
                n_checks++; if (Err !== (last && kind == 3)) $display("FAIL rnd_err n=%0d k=%0d: got %b want %b", n, k, Err, last && kind == 3); else n_pass++;
            end
        end
        @(negedge Clk);
        mem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    initial begin
        Clr       = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misalign();
        test_clr_abort();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
